// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared widths, game phase enum and combo helper for the score keeper
package game_pkg;

  localparam int SCORE_W   = 10;
  localparam int COMBO_MAX = 3;
  localparam int POINTS_W  = 4;
  localparam int LVL_W     = 2;
  localparam int AWARD_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  function automatic logic [LVL_W-1:0] bump_level(input logic [LVL_W-1:0] lvl);
    return (lvl == LVL_W'(COMBO_MAX)) ? lvl : lvl + LVL_W'(1);
  endfunction

endpackage

// File: rtl/combo_tracker.sv
// rtl/combo_tracker.sv - combo window timer, hit history flag and combo level register
module combo_tracker
  import game_pkg::*;
#(
  parameter int COMBO_WINDOW = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_accept,
  input  logic             miss,
  input  logic             clear,
  output logic [LVL_W-1:0] combo_lvl,
  output logic [LVL_W-1:0] hit_lvl
);

  localparam int TMR_W = (COMBO_WINDOW < 1) ? 1 : $clog2(COMBO_WINDOW + 1);
  localparam logic [TMR_W-1:0] WINDOW = TMR_W'(COMBO_WINDOW);

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_inc;
  logic             hist_valid;
  logic             in_window;

  assign in_window = hist_valid && (timer < WINDOW);
  // Level the hit being accepted this cycle earns; the top scales the award with it.
  assign hit_lvl   = in_window ? bump_level(combo_lvl) : '0;
  assign timer_inc = (timer == WINDOW) ? WINDOW : timer + TMR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= WINDOW;
      hist_valid <= 1'b0;
      combo_lvl  <= '0;
    end else if (clear) begin
      timer      <= '0;
      hist_valid <= 1'b0;
      combo_lvl  <= '0;
    end else if (hit_accept) begin
      timer      <= '0;
      hist_valid <= 1'b1;
      combo_lvl  <= hit_lvl;
    end else begin
      timer <= timer_inc;
      if (miss) begin
        hist_valid <= 1'b0;
      end
      // The level drops on the very cycle the timer lands on the window limit.
      if (miss || (timer_inc == WINDOW)) begin
        combo_lvl <= '0;
      end
    end
  end

endmodule

// File: rtl/game_score_keeper.sv
// rtl/game_score_keeper.sv - game phase FSM, clamped score accumulator and session high score
module game_score_keeper
  import game_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int COMBO_WINDOW = CLK_FREQ / 2,
  parameter int SCORE_MAX    = 999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                game_over,
  input  logic                hit_valid,
  input  logic [POINTS_W-1:0] hit_points,
  output logic                hit_ready,
  input  logic                miss,
  output logic [SCORE_W-1:0]  game_score,
  output logic [SCORE_W-1:0]  high_score,
  output logic [LVL_W-1:0]    combo_lvl,
  output logic                playing,
  output logic                new_record
);

  localparam int SUM_W = SCORE_W + 1;
  localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(SCORE_MAX);

  game_state_t state_q, state_d;

  logic               hit_accept;
  logic               miss_accept;
  logic               end_game;
  logic [LVL_W-1:0]   hit_lvl;
  logic [AWARD_W-1:0] award;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] score_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (start) begin
          state_d = ST_PLAY;
        end else if (game_over) begin
          state_d = ST_OVER;
        end
      end
      ST_OVER: if (start) state_d = ST_PLAY;
      default: state_d = ST_IDLE;
    endcase
  end

  assign playing   = (state_q == ST_PLAY);
  assign hit_ready = playing;

  // start beats game_over, game_over beats hits/misses, a hit beats a miss.
  assign end_game    = playing && game_over && !start;
  assign hit_accept  = playing && hit_valid && !start && !game_over;
  assign miss_accept = playing && miss && !hit_valid && !start && !game_over;

  combo_tracker #(
    .COMBO_WINDOW(COMBO_WINDOW)
  ) u_combo (
    .clk       (clk),
    .rst       (rst),
    .hit_accept(hit_accept),
    .miss      (miss_accept),
    .clear     (start),
    .combo_lvl (combo_lvl),
    .hit_lvl   (hit_lvl)
  );

  assign award     = AWARD_W'(hit_points) * (AWARD_W'(hit_lvl) + AWARD_W'(1));
  assign sum       = {1'b0, game_score} + SUM_W'(award);
  assign score_hit = (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_score <= '0;
    end else if (start) begin
      game_score <= '0;
    end else if (hit_accept) begin
      game_score <= score_hit;
    end else if (miss_accept && (game_score != '0)) begin
      game_score <= game_score - SCORE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (end_game && (game_score > high_score)) begin
        high_score <= game_score;
        new_record <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_score_keeper.sv
// tb/tb_game_score_keeper.sv - directed and randomized checks of game_score_keeper against a rule-level model
module tb_game_score_keeper;

  localparam int W   = 100;
  localparam int MAX = 999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, game_over = 1'b0, hit_valid = 1'b0, miss = 1'b0;
  logic [3:0] hit_points = 4'd0;
  logic       hit_ready, playing, new_record;
  logic [9:0] game_score, high_score;
  logic [1:0] combo_lvl;

  int checks = 0;
  int errors = 0;

  // Rule-level model: phase, score, level, cycle index of last accepted hit.
  int m_state, m_score, m_high, m_lvl, m_nr, m_last, cyc;
  bit m_lv;

  game_score_keeper #(
    .CLK_FREQ(200), .COMBO_WINDOW(W), .SCORE_MAX(MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .game_over(game_over),
    .hit_valid(hit_valid), .hit_points(hit_points), .hit_ready(hit_ready),
    .miss(miss), .game_score(game_score), .high_score(high_score),
    .combo_lvl(combo_lvl), .playing(playing), .new_record(new_record)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_lvl = 0; m_nr = 0; m_lv = 0; m_last = 0;
  endtask

  task automatic model_step(input bit st, input bit go, input bit hv, input int hp, input bit ms);
    int nl;
    cyc++;
    m_nr = 0;
    if (st) begin
      m_state = 1; m_score = 0; m_lvl = 0; m_lv = 0;
    end else if (m_state == 1) begin
      if (go) begin
        m_state = 2;
        if (m_score > m_high) begin m_high = m_score; m_nr = 1; end
      end else if (hv) begin
        nl = (m_lv && (cyc - m_last) <= W) ? ((m_lvl >= 3) ? 3 : m_lvl + 1) : 0;
        m_score = m_score + hp * (nl + 1);
        if (m_score > MAX) m_score = MAX;
        m_lvl = nl; m_last = cyc; m_lv = 1;
      end else if (ms) begin
        if (m_score > 0) m_score--;
        m_lvl = 0; m_lv = 0;
      end
    end
    if (m_lv && (cyc - m_last) >= W) m_lvl = 0;
  endtask

  task automatic cycle(input bit st, input bit go, input bit hv, input int hp, input bit ms);
    start = st; game_over = go; hit_valid = hv; hit_points = hp[3:0]; miss = ms;
    @(posedge clk);
    model_step(st, go, hv, hp, ms);
    #1;
    start = 0; game_over = 0; hit_valid = 0; miss = 0; hit_points = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic hit(input int hp);
    cycle(0, 0, 1, hp, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (game_score !== 10'd0) begin errors++; $display("FAIL reset_score got %0d want 0", game_score); end
    checks++; if (high_score !== 10'd0) begin errors++; $display("FAIL reset_high got %0d want 0", high_score); end
    checks++; if (combo_lvl !== 2'd0) begin errors++; $display("FAIL reset_lvl got %0d want 0", combo_lvl); end
    checks++; if ({playing, hit_ready, new_record} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {playing, hit_ready, new_record}); end
    hit(9);
    checks++; if (game_score !== 10'd0) begin errors++; $display("FAIL idle_hit_ignored got %0d want 0", game_score); end
  endtask

  task automatic test_combo_chain();
    int exp_s[3] = '{5, 15, 30};
    int exp_l[3] = '{0, 1, 2};
    cycle(1, 0, 0, 0, 0);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL start_playing got %0d want 1", playing); end
    for (int i = 0; i < 3; i++) begin
      hit(5);
      checks++; if (game_score !== 10'(exp_s[i])) begin errors++; $display("FAIL chain_score%0d got %0d want %0d", i, game_score, exp_s[i]); end
      checks++; if (combo_lvl !== 2'(exp_l[i])) begin errors++; $display("FAIL chain_lvl%0d got %0d want %0d", i, combo_lvl, exp_l[i]); end
      idle(9);
    end
  endtask

  task automatic test_window();
    cycle(1, 0, 0, 0, 0);
    hit(4);
    idle(100);
    hit(4);
    checks++; if (game_score !== 10'd8) begin errors++; $display("FAIL window_score got %0d want 8", game_score); end
    checks++; if (combo_lvl !== 2'd0) begin errors++; $display("FAIL window_lvl got %0d want 0", combo_lvl); end
    hit(4);
    checks++; if (game_score !== 10'd16 || combo_lvl !== 2'd1) begin errors++; $display("FAIL window_combo got %0d/%0d want 16/1", game_score, combo_lvl); end
    idle(99);
    checks++; if (combo_lvl !== 2'd1) begin errors++; $display("FAIL window_hold got %0d want 1", combo_lvl); end
    idle(1);
    checks++; if (combo_lvl !== 2'd0) begin errors++; $display("FAIL window_decay got %0d want 0", combo_lvl); end
  endtask

  task automatic test_clamp();
    cycle(1, 0, 0, 0, 0);
    repeat (18) hit(15);
    checks++; if (game_score !== 10'd990) begin errors++; $display("FAIL clamp_build got %0d want 990", game_score); end
    idle(100);
    hit(15);
    checks++; if (game_score !== 10'd999 || combo_lvl !== 2'd0) begin errors++; $display("FAIL clamp_first got %0d/%0d want 999/0", game_score, combo_lvl); end
    hit(15);
    checks++; if (game_score !== 10'd999) begin errors++; $display("FAIL clamp_hold got %0d want 999", game_score); end
  endtask

  task automatic test_miss();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    checks++; if (game_score !== 10'd0) begin errors++; $display("FAIL miss_floor got %0d want 0", game_score); end
    hit(0); hit(0); hit(1);
    checks++; if (game_score !== 10'd3 || combo_lvl !== 2'd2) begin errors++; $display("FAIL miss_setup got %0d/%0d want 3/2", game_score, combo_lvl); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (game_score !== 10'd2 || combo_lvl !== 2'd0) begin errors++; $display("FAIL miss_penalty got %0d/%0d want 2/0", game_score, combo_lvl); end
    cycle(0, 0, 1, 5, 1);
    checks++; if (game_score !== 10'd7 || combo_lvl !== 2'd0) begin errors++; $display("FAIL hit_beats_miss got %0d/%0d want 7/0", game_score, combo_lvl); end
  endtask

  task automatic test_high_score();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (4) hit(10);
    hit(5);
    checks++; if (game_score !== 10'd120) begin errors++; $display("FAIL hs_build got %0d want 120", game_score); end
    cycle(0, 1, 0, 0, 0);
    checks++; if (high_score !== 10'd120 || new_record !== 1'b1) begin errors++; $display("FAIL hs_record got %0d/%0d want 120/1", high_score, new_record); end
    checks++; if (hit_ready !== 1'b0 || playing !== 1'b0) begin errors++; $display("FAIL hs_ready got %0d/%0d want 0/0", hit_ready, playing); end
    hit(9);
    checks++; if (new_record !== 1'b0 || game_score !== 10'd120) begin errors++; $display("FAIL hs_over_hold got %0d/%0d want 0/120", new_record, game_score); end
    cycle(1, 0, 0, 0, 0);
    repeat (4) hit(10);
    hit(5);
    cycle(0, 1, 0, 0, 0);
    checks++; if (new_record !== 1'b0 || high_score !== 10'd120) begin errors++; $display("FAIL hs_equal got %0d/%0d want 0/120", new_record, high_score); end
    cycle(1, 0, 0, 0, 0);
    repeat (4) hit(5);
    cycle(0, 1, 1, 9, 0);
    checks++; if (game_score !== 10'd50 || high_score !== 10'd120 || new_record !== 1'b0) begin errors++; $display("FAIL hs_lower got %0d/%0d/%0d want 50/120/0", game_score, high_score, new_record); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0, 0);
    hit(15); hit(15); hit(8); hit(2);
    checks++; if (game_score !== 10'd77) begin errors++; $display("FAIL rst_build got %0d want 77", game_score); end
    rst = 1;
    #2;
    checks++; if (game_score !== 10'd0 || high_score !== 10'd0 || combo_lvl !== 2'd0) begin errors++; $display("FAIL rst_async got %0d/%0d/%0d want 0/0/0", game_score, high_score, combo_lvl); end
    checks++; if (playing !== 1'b0 || new_record !== 1'b0) begin errors++; $display("FAIL rst_async_flags got %0d/%0d want 0/0", playing, new_record); end
    @(negedge clk) rst = 0;
    model_reset();
    hit(7); hit(7);
    checks++; if (game_score !== 10'd0 || playing !== 1'b0) begin errors++; $display("FAIL rst_hits_ignored got %0d/%0d want 0/0", game_score, playing); end
    cycle(1, 0, 0, 0, 0);
    checks++; if (playing !== 1'b1 || game_score !== 10'd0) begin errors++; $display("FAIL rst_restart got %0d/%0d want 1/0", playing, game_score); end
  endtask

  task automatic test_random();
    bit dense;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dense = ($urandom_range(0, 1) == 1);
      cycle(($urandom % 60) == 0, ($urandom % 50) == 0,
            dense ? ($urandom % 2 == 0) : ($urandom % 80 == 0),
            $urandom_range(0, 15), ($urandom % 10) == 0);
      checks++; if (game_score !== 10'(m_score)) begin errors++; $display("FAIL rnd_score cyc %0d got %0d want %0d", i, game_score, m_score); end
      checks++; if (high_score !== 10'(m_high)) begin errors++; $display("FAIL rnd_high cyc %0d got %0d want %0d", i, high_score, m_high); end
      checks++; if (combo_lvl !== 2'(m_lvl)) begin errors++; $display("FAIL rnd_lvl cyc %0d got %0d want %0d", i, combo_lvl, m_lvl); end
      checks++; if (playing !== (m_state == 1) || hit_ready !== (m_state == 1)) begin errors++; $display("FAIL rnd_playing cyc %0d got %0d/%0d want %0d", i, playing, hit_ready, m_state == 1); end
      checks++; if (new_record !== 1'(m_nr)) begin errors++; $display("FAIL rnd_record cyc %0d got %0d want %0d", i, new_record, m_nr); end
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_combo_chain();
    test_window();
    test_clamp();
    test_miss();
    test_high_score();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
